// File: rtl/pet_memmap.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : pet_memmap                                                     |
// | Brief  : PET 2001/3032/4032/8096 memory-map controller. Decodes the CPU |
// |          address onto RAM/ROM/VRAM/I-O, implements the 8096 bank-      |
// |          switched expansion with its $FFF0 control register, and a     |
// |          4-phase DMA port that owns the memory ports while the CPU is  |
// |          halted.                                                       |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module pet_memmap #(
  parameter int RAM_KB  = 32,   // base RAM size in KB (8, 16 or 32)
  parameter int EXP_EN  = 0,    // 1 = 8096 expansion + $FFF0 register
  parameter int VRAM_AW = 10    // 10 = 40-column, 11 = 80-column
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce_1m,
  // CPU bus
  input  logic [15:0]        addr,
  input  logic [7:0]         data_in,
  input  logic               we,
  output logic [7:0]         data_out,
  input  logic               cpu_halt,
  // RAM port
  output logic [16:0]        ram_addr,
  output logic [7:0]         ram_din,
  output logic               ram_we,
  input  logic [7:0]         ram_q,
  // ROM port (write side is only used for DMA uploads)
  output logic [14:0]        rom_addr,
  output logic [7:0]         rom_din,
  output logic               rom_we,
  input  logic [7:0]         rom_q,
  // VRAM CPU port
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_din,
  output logic               vram_we,
  input  logic [7:0]         vram_q,
  // I/O block
  output logic               io_cs,
  input  logic [7:0]         io_q,
  // DMA port
  input  logic [16:0]        dma_addr,
  input  logic [7:0]         dma_din,
  input  logic               dma_we,
  input  logic               dma_req,
  output logic               dma_ack,
  output logic [7:0]         dma_dout,
  // control register
  output logic [7:0]         ctrl
);

  // Base RAM occupies $0000 up to (but excluding) this address.
  localparam logic [16:0] c_ram_bytes = 17'(RAM_KB * 1024);

  // Read-source codes carried alongside the 1-clk memory latency.
  localparam logic [2:0] c_src_ram  = 3'd0;
  localparam logic [2:0] c_src_vram = 3'd1;
  localparam logic [2:0] c_src_rom  = 3'd2;
  localparam logic [2:0] c_src_io   = 3'd3;
  localparam logic [2:0] c_src_open = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } dma_state_t;

  dma_state_t  state_q, state_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [2:0]  src_q, src_d;
  logic [7:0]  open_q, open_d;
  logic [7:0]  data_out_q, data_out_d;
  logic [7:0]  dma_dout_q, dma_dout_d;
  logic        dma_ack_q, dma_ack_d;

  logic        w_ctrl_sel;
  logic        w_exp_on;
  logic        w_in_vram_win;
  logic        w_in_io_win;
  logic        w_sel_ram;
  logic        w_sel_vram;
  logic        w_sel_io;
  logic        w_wr_ok;
  logic [2:0]  w_src;
  logic [16:0] w_cpu_ram_addr;
  logic        w_dma_own;
  logic        w_cpu_wr;

  // The $FFF0 register only exists on the expansion build; otherwise
  // ctrl can never be written and the expansion decode stays dormant.
  generate
    if (EXP_EN != 0) begin : g_exp
      assign w_ctrl_sel = (addr == 16'hFFF0);
    end else begin : g_no_exp
      assign w_ctrl_sel = 1'b0;
    end
  endgenerate

  assign w_exp_on      = ctrl_q[7];
  assign w_in_vram_win = (addr[15:12] == 4'h8);
  assign w_in_io_win   = (addr[15:11] == 5'b11101);   // $E800-$EFFF

  // DMA takes the memory ports as soon as a request is accepted so the
  // read data is ready by the time the FSM leaves ACCESS.
  assign w_dma_own = (state_q != ST_IDLE) || (dma_req && cpu_halt);
  assign w_cpu_wr  = we && ce_1m && !w_dma_own;

  // CPU address decode: target select, write permission and RAM mapping.
  always_comb begin
    w_sel_ram      = 1'b0;
    w_sel_vram     = 1'b0;
    w_sel_io       = 1'b0;
    w_wr_ok        = 1'b0;
    w_src          = c_src_open;
    w_cpu_ram_addr = {2'b00, addr[14:0]};
    if (w_exp_on && addr[15]) begin
      if (ctrl_q[5] && w_in_vram_win) begin
        w_sel_vram = 1'b1;
        w_src      = c_src_vram;
      end else if (ctrl_q[6] && w_in_io_win) begin
        w_sel_io = 1'b1;
        w_src    = c_src_io;
      end else begin
        // Upper 32K is split into two 16K windows, each with its own bank bit
        // and write-protect bit.
        w_sel_ram      = 1'b1;
        w_src          = c_src_ram;
        w_cpu_ram_addr = {1'b1, addr[14], (addr[14] ? ctrl_q[3] : ctrl_q[2]), addr[13:0]};
        w_wr_ok        = addr[14] ? !ctrl_q[1] : !ctrl_q[0];
      end
    end else if (!addr[15]) begin
      if ({1'b0, addr} < c_ram_bytes) begin
        w_sel_ram = 1'b1;
        w_wr_ok   = 1'b1;
        w_src     = c_src_ram;
      end
    end else if (w_in_vram_win) begin
      w_sel_vram = 1'b1;
      w_src      = c_src_vram;
    end else if (w_in_io_win) begin
      w_sel_io = 1'b1;
      w_src    = c_src_io;
    end else begin
      w_src = c_src_rom;
    end
  end

  // Memory port drive: CPU by default, DMA while it owns the bus; no write
  // enable ever leaves the block while reset is asserted.
  always_comb begin
    ram_addr  = w_cpu_ram_addr;
    ram_din   = data_in;
    ram_we    = w_cpu_wr && w_sel_ram && w_wr_ok && !w_ctrl_sel;
    rom_addr  = addr[14:0];
    rom_din   = dma_din;
    rom_we    = 1'b0;
    vram_addr = addr[VRAM_AW-1:0];
    vram_din  = data_in;
    vram_we   = w_cpu_wr && w_sel_vram && !w_ctrl_sel;
    io_cs     = w_sel_io && !w_dma_own;
    if (w_dma_own) begin
      ram_addr = dma_addr;
      ram_din  = dma_din;
      rom_addr = dma_addr[14:0];
      ram_we   = (state_q == ST_ACCESS) && dma_we && dma_addr[16];
      rom_we   = (state_q == ST_ACCESS) && dma_we && !dma_addr[16];
      vram_we  = 1'b0;
    end
    if (!reset_n) begin
      ram_we  = 1'b0;
      rom_we  = 1'b0;
      vram_we = 1'b0;
    end
  end

  // Next-state logic: ctrl load, read pipeline and DMA handshake FSM.
  always_comb begin
    ctrl_d     = ctrl_q;
    src_d      = w_src;
    open_d     = addr[15:8];
    state_d    = state_q;
    dma_dout_d = dma_dout_q;

    if (w_cpu_wr && w_ctrl_sel) begin
      ctrl_d = data_in;
    end

    case (src_q)
      c_src_ram:  data_out_d = ram_q;
      c_src_vram: data_out_d = vram_q;
      c_src_rom:  data_out_d = rom_q;
      c_src_io:   data_out_d = io_q;
      default:    data_out_d = open_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (dma_req && cpu_halt) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Address was presented one clk earlier, so q is already valid here.
        state_d    = ST_ACK;
        dma_dout_d = dma_addr[16] ? ram_q : rom_q;
      end
      ST_ACK: begin
        if (!dma_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    dma_ack_d = (state_d == ST_ACK);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= 8'h00;
      src_q      <= c_src_open;
      open_q     <= 8'h00;
      data_out_q <= 8'h00;
      dma_dout_q <= 8'h00;
      dma_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      src_q      <= src_d;
      open_q     <= open_d;
      data_out_q <= data_out_d;
      dma_dout_q <= dma_dout_d;
      dma_ack_q  <= dma_ack_d;
    end
  end

  assign data_out = data_out_q;
  assign dma_dout = dma_dout_q;
  assign dma_ack  = dma_ack_q;
  assign ctrl     = ctrl_q;

endmodule
`default_nettype wire
